// File: rtl/fifo_merge_rr.sv
// rtl/fifo_merge_rr.sv - round-robin merge of N per-TID input heads into one valid/ready output register
// Optional TID check on each grant: define FIFO_MERGE_TID_CHECK_EN.
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif

module fifo_merge_rr #(
   parameter int N          = 3,
   parameter int DATA_WIDTH = 32,
   localparam int SW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [0:N-1]          empty_n,
   output logic [0:N-1]          read,
   input  logic [DATA_WIDTH-1:0] din [0:N-1],
   output logic                  valid,
   input  logic                  ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [SW-1:0]         src,
   output logic                  err
);

   logic [SW-1:0] ptr;
   logic [SW-1:0] win;
   logic [SW-1:0] ptr_next;
   logic          found;
   logic          slot;
   logic          grant;

   // First non-empty input scanning ptr, ptr+1, ... with wrap.
   always_comb begin
      int j;
      j     = 0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && empty_n[j]) begin
            found = 1'b1;
            win   = SW'(j);
         end
      end
   end

   assign slot     = !valid || ready;
   assign grant    = slot && found && arst_n;
   assign ptr_next = (win == SW'(N - 1)) ? '0 : win + 1'b1;

   always_comb begin
      read = '0;
      if (grant) read[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         valid <= 1'b0;
         dout  <= '0;
         src   <= '0;
         ptr   <= '0;
      end else if (grant) begin
         valid <= 1'b1;
         dout  <= din[win];
         src   <= win;
         ptr   <= ptr_next;
      end else if (slot) begin
         valid <= 1'b0;
      end
   end

`ifdef FIFO_MERGE_TID_CHECK_EN
   // Sticky: the word is still loaded even when its TID is wrong.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err <= 1'b0;
      end else if (grant && (din[win][`TID_WIDTH-1:0] != `TID_WIDTH'(win))) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_merge_rr.sv
// tb/tb_fifo_merge_rr.sv - randomized self-checking bench for fifo_merge_rr against a queue-level reference model
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif

module tb_fifo_merge_rr;
   localparam int N  = 3;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          ready = 1'b0;
   logic [0:N-1]  empty_n = '0;
   logic [0:N-1]  read;
   logic [DW-1:0] din [0:N-1];
   logic          valid;
   logic [DW-1:0] dout;
   logic [1:0]    src;
   logic          err;

   int checks = 0;
   int failures = 0;

   bit            m_valid;
   bit            m_err;
   logic [DW-1:0] m_dout;
   int            m_src;
   int            m_ptr;

   fifo_merge_rr #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk(clk), .arst_n(arst_n), .empty_n(empty_n), .read(read), .din(din),
      .valid(valid), .ready(ready), .dout(dout), .src(src), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_err = 0; m_dout = '0; m_src = 0; m_ptr = 0;
   endtask

   function automatic int pick(input logic [0:N-1] en, input int p);
      for (int k = 0; k < N; k++)
         if (en[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic rand_inputs(input int pct_full, input int pct_ready);
      for (int i = 0; i < N; i++) begin
         empty_n[i] = ($urandom_range(0, 99) < pct_full);
         din[i] = $urandom;
         if ($urandom_range(0, 3) != 0) din[i][`TID_WIDTH-1:0] = `TID_WIDTH'(i);
      end
      ready = ($urandom_range(0, 99) < pct_ready);
   endtask

   // Check outputs mid-cycle against the model, advance the model, then step past the next edge.
   task automatic cycle();
      logic [0:N-1] exp_read;
      bit slot;
      int w;
      @(negedge clk);
      slot = !m_valid || ready;
      w = pick(empty_n, m_ptr);
      exp_read = '0;
      if (slot && w >= 0) exp_read[w] = 1'b1;
      check("read", 64'(read), 64'(exp_read));
      check("valid", 64'(valid), 64'(m_valid));
      check("dout", 64'(dout), 64'(m_dout));
      check("src", 64'(src), 64'(m_src));
      check("err", 64'(err), 64'(m_err));
      if (slot && w >= 0) begin
`ifdef FIFO_MERGE_TID_CHECK_EN
         if (din[w][`TID_WIDTH-1:0] != `TID_WIDTH'(w)) m_err = 1;
`endif
         m_valid = 1; m_dout = din[w]; m_src = w; m_ptr = (w + 1) % N;
      end else if (slot) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) din[i] = DW'(i);
      model_reset();

      // Reset held with every input non-empty.
      empty_n = '1; ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_read", 64'(read), 64'd0);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      arst_n = 1'b1;

      // Round-robin with everything full: src 0,1,2,0,1,2.
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++) din[i] = {24'h00AB00 + 24'(c), 8'(i)};
         cycle();
         check("rr_src", 64'(src), 64'(c % N));
         check("rr_valid", 64'(valid), 64'd1);
      end

      // Backpressure holds the word tid=1 for five cycles, then grant in the same cycle as ready.
      empty_n = 3'b010; din[1] = 32'h0000_0101; ready = 1'b1;
      cycle();
      check("bp_load_src", 64'(src), 64'd1);
      empty_n = '1; ready = 1'b0;
      repeat (5) begin
         cycle();
         check("bp_hold_dout", 64'(dout), 64'h0000_0101);
         check("bp_hold_src", 64'(src), 64'd1);
      end
      ready = 1'b1;
      cycle();

      // Drain, then a single word on input 2 only.
      empty_n = '0;
      repeat (2) cycle();
      empty_n = 3'b001; din[2] = 32'h0000_0042;
      cycle();
      check("sparse_valid", 64'(valid), 64'd1);
      check("sparse_dout", 64'(dout), 64'h42);
      check("sparse_src", 64'(src), 64'd2);
      empty_n = '0;
      cycle();
      check("sparse_empty", 64'(valid), 64'd0);
      check("sparse_stale", 64'(dout), 64'h42);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         rand_inputs((c < 1500) ? 60 : 95, (c % 500 < 250) ? 50 : 90);
         cycle();
      end

      // Mid-stream reset while holding a word under backpressure.
      empty_n = '1; ready = 1'b1;
      cycle();
      ready = 1'b0;
      cycle();
      check("mid_pre_valid", 64'(valid), 64'd1);
      #2;
      arst_n = 1'b0;
      #1;
      check("mid_valid", 64'(valid), 64'd0);
      check("mid_read", 64'(read), 64'd0);
      check("mid_dout", 64'(dout), 64'd0);
      check("mid_err", 64'(err), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      ready = 1'b1;
      cycle();
      check("mid_restart_src", 64'(src), 64'd0);
      cycle();
      check("mid_next_src", 64'(src), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
